// File: rtl/orb_frame_decoder.sv
// Orbita M8 loopback receiver: hunts for the group sync word on bit strobes, confirms lock over
// consecutive groups, then deserializes 12-bit words and writes them with their in-group address.
module orb_frame_decoder #(
  parameter int          GROUP_WORDS = 1024,
  parameter logic [11:0] SYNC_WORD   = 12'hE38,
  parameter int          LOCK_GROUPS = 2,
  parameter int          MISS_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iSerial,
  input  logic        iBitEn,
  output logic [11:0] oData,
  output logic [9:0]  oAddr,
  output logic        oWrEn,
  output logic        oGroupStart,
  output logic        oLocked,
  output logic [15:0] oErrCnt
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_CHECK,
    ST_LOCKED
  } state_e;

  localparam logic [9:0]  WORD_MASK = 10'(GROUP_WORDS - 1);
  localparam logic [15:0] LOCK_N    = 16'(LOCK_GROUPS);
  localparam logic [15:0] MISS_N    = 16'(MISS_LIMIT);
  localparam logic [3:0]  FILL_FULL = 4'd12;
  localparam logic [3:0]  LAST_BIT  = 4'd11;

  state_e      state_q, state_d;
  logic [11:0] shift_q, shift_d;
  logic [3:0]  fill_q, fill_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  word_q, word_d;
  logic [15:0] confirm_q, confirm_d;
  logic [15:0] miss_q, miss_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [11:0] data_q, data_d;
  logic [9:0]  addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        gs_q, gs_d;
  logic        locked_q, locked_d;

  logic [11:0] shift_next;
  logic        sync_hit;
  logic        word_done;

  assign shift_next = {shift_q[10:0], iSerial};
  assign sync_hit   = (shift_next == SYNC_WORD);
  assign word_done  = (bit_q == LAST_BIT);

  // NOTE: every variable gets its hold value before any branch, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    fill_d    = fill_q;
    bit_d     = bit_q;
    word_d    = word_q;
    confirm_d = confirm_q;
    miss_d    = miss_q;
    err_cnt_d = err_cnt_q;
    data_d    = data_q;
    addr_d    = addr_q;
    wr_d      = 1'b0;
    gs_d      = 1'b0;
    locked_d  = locked_q;

    if (iBitEn) begin
      shift_d = shift_next;
      unique case (state_q)
        ST_HUNT: begin
          fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 4'd1;
          if (fill_d == FILL_FULL && sync_hit) begin
            state_d   = ST_CHECK;
            bit_d     = '0;
            word_d    = 10'd1 & WORD_MASK;
            confirm_d = '0;
          end
        end

        ST_CHECK: begin
          bit_d = word_done ? '0 : bit_q + 4'd1;
          if (word_done) begin
            word_d = (word_q + 10'd1) & WORD_MASK;
            if (word_q == '0) begin
              if (sync_hit) begin
                confirm_d = confirm_q + 16'd1;
                if (confirm_d == LOCK_N) begin
                  // The marker that completes confirmation is also the first write of the group.
                  state_d  = ST_LOCKED;
                  locked_d = 1'b1;
                  miss_d   = '0;
                  wr_d     = 1'b1;
                  data_d   = shift_next;
                  addr_d   = word_q;
                  gs_d     = 1'b1;
                end
              end else begin
                state_d = ST_HUNT;
                fill_d  = '0;
              end
            end
          end
        end

        ST_LOCKED: begin
          bit_d = word_done ? '0 : bit_q + 4'd1;
          if (word_done) begin
            word_d = (word_q + 10'd1) & WORD_MASK;
            wr_d   = 1'b1;
            data_d = shift_next;
            addr_d = word_q;
            gs_d   = (word_q == '0);
            if (word_q == '0) begin
              if (sync_hit) begin
                miss_d = '0;
              end else begin
                miss_d    = miss_q + 16'd1;
                err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                if (miss_d == MISS_N) begin
                  state_d  = ST_HUNT;
                  fill_d   = '0;
                  locked_d = 1'b0;
                end
              end
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
          fill_d  = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_HUNT;
      shift_q   <= '0;
      fill_q    <= '0;
      bit_q     <= '0;
      word_q    <= '0;
      confirm_q <= '0;
      miss_q    <= '0;
      err_cnt_q <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      gs_q      <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      fill_q    <= fill_d;
      bit_q     <= bit_d;
      word_q    <= word_d;
      confirm_q <= confirm_d;
      miss_q    <= miss_d;
      err_cnt_q <= err_cnt_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      gs_q      <= gs_d;
      locked_q  <= locked_d;
    end
  end

  assign oData       = data_q;
  assign oAddr       = addr_q;
  assign oWrEn       = wr_q;
  assign oGroupStart = gs_q;
  assign oLocked     = locked_q;
  assign oErrCnt     = err_cnt_q;

endmodule

// File: tb/tb_orb_frame_decoder.sv
// Bench for orb_frame_decoder: a small-group instance checked every cycle against a positional
// model, a full-size instance for the 1024-word lock sequence, and a small instance for saturation.
module tb_orb_frame_decoder;

  localparam logic [11:0] SYNC = 12'hE38;
  localparam logic [11:0] BAD  = 12'h000;
  localparam int M_GW = 16;
  localparam int M_LG = 2;
  localparam int M_ML = 3;
  localparam int S_GW = 4;
  localparam int B_GW = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic m_rst = 1'b1;
  logic b_rst = 1'b1;
  logic s_rst = 1'b1;
  logic        ser    [3];
  logic        en     [3];
  logic [11:0] o_data [3];
  logic [9:0]  o_addr [3];
  logic        o_wr   [3];
  logic        o_gs   [3];
  logic        o_lock [3];
  logic [15:0] o_err  [3];

  int n_cmp = 0;
  int n_bad = 0;

  orb_frame_decoder #(.GROUP_WORDS(M_GW), .SYNC_WORD(SYNC), .LOCK_GROUPS(M_LG), .MISS_LIMIT(M_ML)) u_main (
    .clk(clk), .reset(m_rst), .iSerial(ser[0]), .iBitEn(en[0]),
    .oData(o_data[0]), .oAddr(o_addr[0]), .oWrEn(o_wr[0]), .oGroupStart(o_gs[0]),
    .oLocked(o_lock[0]), .oErrCnt(o_err[0])
  );

  orb_frame_decoder u_big (
    .clk(clk), .reset(b_rst), .iSerial(ser[1]), .iBitEn(en[1]),
    .oData(o_data[1]), .oAddr(o_addr[1]), .oWrEn(o_wr[1]), .oGroupStart(o_gs[1]),
    .oLocked(o_lock[1]), .oErrCnt(o_err[1])
  );

  orb_frame_decoder #(.GROUP_WORDS(S_GW), .SYNC_WORD(SYNC), .LOCK_GROUPS(2), .MISS_LIMIT(1000)) u_sat (
    .clk(clk), .reset(s_rst), .iSerial(ser[2]), .iBitEn(en[2]),
    .oData(o_data[2]), .oAddr(o_addr[2]), .oWrEn(o_wr[2]), .oGroupStart(o_gs[2]),
    .oLocked(o_lock[2]), .oErrCnt(o_err[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  // Grid position is tracked as a bit offset from the last accepted marker; word index and
  // word completion fall out of plain division.
  int          md_mode;   // 0 hunting, 1 confirming, 2 locked
  int          md_hunt;
  int          md_pos;
  int          md_conf;
  int          md_miss;
  int          md_err;
  logic [11:0] md_win;
  logic        md_wr, md_gs, md_lock;
  logic [11:0] md_data;
  logic [9:0]  md_addr;

  task automatic model_emit(input logic [11:0] w, input int idx);
    md_wr   = 1'b1;
    md_data = w;
    md_addr = 10'(idx);
    md_gs   = (idx == 0);
  endtask

  task automatic model_step();
    int idx;
    bit done;
    if (!m_rst) begin
      md_mode = 0; md_hunt = 0; md_pos = 0; md_conf = 0; md_miss = 0; md_err = 0;
      md_win = '0; md_wr = 1'b0; md_gs = 1'b0; md_lock = 1'b0; md_data = '0; md_addr = '0;
      return;
    end
    md_wr = 1'b0;
    md_gs = 1'b0;
    if (!en[0]) return;
    md_win = {md_win[10:0], ser[0]};
    if (md_mode == 0) begin
      md_hunt++;
      if (md_hunt >= 12 && md_win == SYNC) begin
        md_mode = 1;
        md_pos  = 12;
        md_conf = 0;
      end
      return;
    end
    idx    = (md_pos / 12) % M_GW;
    done   = ((md_pos % 12) == 11);
    md_pos = (md_pos + 1) % (12 * M_GW);
    if (!done) return;
    if (md_mode == 2) model_emit(md_win, idx);
    if (idx != 0) return;
    if (md_mode == 1) begin
      if (md_win == SYNC) begin
        md_conf++;
        if (md_conf == M_LG) begin
          md_mode = 2; md_lock = 1'b1; md_miss = 0;
          model_emit(md_win, 0);
        end
      end else begin
        md_mode = 0; md_hunt = 0;
      end
    end else if (md_win == SYNC) begin
      md_miss = 0;
    end else begin
      md_miss++;
      if (md_err < 65535) md_err++;
      if (md_miss == M_ML) begin
        md_mode = 0; md_hunt = 0; md_lock = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge m_rst);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("main_wr",   32'(o_wr[0]),   32'(md_wr));
      check("main_gs",   32'(o_gs[0]),   32'(md_gs));
      check("main_lock", 32'(o_lock[0]), 32'(md_lock));
      check("main_err",  32'(o_err[0]),  32'(md_err));
      check("main_data", 32'(o_data[0]), 32'(md_data));
      check("main_addr", 32'(o_addr[0]), 32'(md_addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [11:0] rand_word();
    return ($urandom & 1) != 0 ? 12'hFFF : 12'h000;
  endfunction

  // Called at a falling edge; returns at the next falling edge, when the strobe's outputs are visible.
  task automatic send_bit(input int ch, input logic b);
    ser[ch] = b;
    en[ch]  = 1'b1;
    @(negedge clk);
    en[ch]  = 1'b0;
  endtask

  task automatic send_word(input int ch, input logic [11:0] w, input bit quarter);
    for (int i = 11; i >= 0; i--) begin
      if (quarter) begin
        repeat (3) begin
          ser[ch] = 1'($urandom & 1);
          @(negedge clk);
        end
      end
      send_bit(ch, w[i]);
    end
  endtask

  task automatic big_word(input logic [11:0] w, input bit exp_wr, input int idx, input bit exp_lock);
    for (int i = 11; i >= 0; i--) begin
      send_bit(1, w[i]);
      check("big_wr", 32'(o_wr[1]), 32'(exp_wr && i == 0));
      if (exp_wr && i == 0) begin
        check("big_addr", 32'(o_addr[1]), 32'(idx));
        check("big_data", 32'(o_data[1]), 32'(w));
        check("big_gs",   32'(o_gs[1]),   32'(idx == 0));
      end
    end
    check("big_lock", 32'(o_lock[1]), 32'(exp_lock));
  endtask

  task automatic main_pins(input string tag, input logic lock, input int err);
    check({tag, "_lock"}, 32'(o_lock[0]), 32'(lock));
    check({tag, "_err"},  32'(o_err[0]),  32'(err));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] mk;
    int          sat_exp;
    for (int i = 0; i < 3; i++) begin
      ser[i] = 1'b0;
      en[i]  = 1'b0;
    end
    #1;
    m_rst = 1'b0; b_rst = 1'b0; s_rst = 1'b0;
    repeat (3) @(negedge clk);
    m_rst = 1'b1; b_rst = 1'b1; s_rst = 1'b1;
    main_pins("rst", 1'b0, 0);
    check("rst_wr",   32'(o_wr[0]),   32'd0);
    check("rst_data", 32'(o_data[0]), 32'd0);
    check("rst_addr", 32'(o_addr[0]), 32'd0);

    // Decoy sync pattern off the group grid, then the real groups.
    repeat (20) send_bit(0, 1'b0);
    send_word(0, SYNC, 1'b0);
    repeat (5) send_word(0, rand_word(), 1'b0);
    for (int g = 0; g < 10; g++) begin
      mk = (g == 4 || g == 5 || g == 7 || g == 8 || g == 9) ? BAD : SYNC;
      send_word(0, mk, 1'b0);
      if (g == 2) main_pins("confirm", 1'b0, 0);
      if (g == 3) begin
        main_pins("lock", 1'b1, 0);
        check("lock_wr",   32'(o_wr[0]),   32'd1);
        check("lock_addr", 32'(o_addr[0]), 32'd0);
        check("lock_data", 32'(o_data[0]), 32'(SYNC));
        check("lock_gs",   32'(o_gs[0]),   32'd1);
      end
      if (g == 5) main_pins("miss2", 1'b1, 2);
      if (g == 6) main_pins("good", 1'b1, 2);
      if (g == 8) main_pins("miss4", 1'b1, 4);
      if (g == 9) begin
        main_pins("drop", 1'b0, 5);
        check("drop_wr",   32'(o_wr[0]),   32'd1);
        check("drop_addr", 32'(o_addr[0]), 32'd0);
        check("drop_data", 32'(o_data[0]), 32'(BAD));
      end
      repeat (M_GW - 1) send_word(0, rand_word(), 1'b0);
    end

    // Relock with one strobe in four.
    for (int g = 0; g < 3; g++) begin
      send_word(0, SYNC, 1'b1);
      if (g == 1) main_pins("q_confirm", 1'b0, 5);
      if (g == 2) begin
        main_pins("q_lock", 1'b1, 5);
        check("q_wr", 32'(o_wr[0]), 32'd1);
        @(negedge clk);
        check("q_wr_pulse", 32'(o_wr[0]), 32'd0);
      end
      repeat (M_GW - 1) send_word(0, rand_word(), 1'b1);
    end

    // Reset mid-word while locked.
    send_word(0, SYNC, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    check("pre_rst_lock", 32'(o_lock[0]), 32'd1);
    #2 m_rst = 1'b0;
    #1;
    main_pins("async_rst", 1'b0, 0);
    check("async_rst_wr",   32'(o_wr[0]),   32'd0);
    check("async_rst_gs",   32'(o_gs[0]),   32'd0);
    check("async_rst_data", 32'(o_data[0]), 32'd0);
    check("async_rst_addr", 32'(o_addr[0]), 32'd0);
    repeat (2) @(negedge clk);
    m_rst = 1'b1;
    repeat (20) send_bit(0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      send_word(0, SYNC, 1'b0);
      main_pins("relock", (g == 2), 0);
      repeat (M_GW - 1) send_word(0, rand_word(), 1'b0);
    end

    // Full-size groups: lock on the third marker, then one write per word.
    for (int i = 0; i < 20; i++) begin
      send_bit(1, 1'b0);
      check("big_pre_wr", 32'(o_wr[1]), 32'd0);
    end
    for (int g = 0; g < 3; g++) begin
      big_word(SYNC, (g == 2), 0, (g == 2));
      for (int k = 1; k < B_GW; k++) big_word(rand_word(), (g == 2), k, (g == 2));
    end
    big_word(SYNC, 1'b1, 0, 1'b1);

    // Error counter saturation with a long run of bad markers.
    repeat (20) send_bit(2, 1'b0);
    for (int g = 0; g < 3; g++) begin
      send_word(2, SYNC, 1'b0);
      repeat (S_GW - 1) send_word(2, rand_word(), 1'b0);
    end
    check("sat_lock", 32'(o_lock[2]), 32'd1);
    force u_sat.err_cnt_q = 16'hFFFC;
    @(negedge clk);
    release u_sat.err_cnt_q;
    @(negedge clk);
    sat_exp = 'hFFFC;
    for (int k = 0; k < 6; k++) begin
      send_word(2, BAD, 1'b0);
      if (sat_exp < 'hFFFF) sat_exp++;
      check("sat_err",  32'(o_err[2]),  32'(sat_exp));
      check("sat_held", 32'(o_lock[2]), 32'd1);
      repeat (S_GW - 1) send_word(2, rand_word(), 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: time limit reached at %0t, expected finish earlier", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/orb_frame_decoder.md
# orb_frame_decoder

Loopback receiver for the Orbita M8 serial group stream produced by the frame former: samples the serial line on bit strobes, hunts for the group sync word, confirms lock over consecutive groups, then deserializes 12-bit words and writes them with word addresses into a group buffer write port. Sits directly downstream of the frame former's serial output on the same clock domain and is used for self-test and link monitoring.

## Interface

- GROUP_WORDS, 1024: words per group, including the sync word at index 0; power of two, at most 1024.
- SYNC_WORD, 12'hE38: marker value carried in word 0 of every group; must be nonzero.
- LOCK_GROUPS, 2: consecutive correctly spaced markers, after the first, required to declare lock.
- MISS_LIMIT, 3: consecutive missed markers while locked that drop lock.

- clk  in  1  frame clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- iSerial  in  1  serial group data, MSB of each word first.
- iBitEn  in  1  bit strobe; iSerial valid when high; may be held high continuously.
- oData  out  12  assembled word.
- oAddr  out  10  word index within group, 0..GROUP_WORDS-1.
- oWrEn  out  1  one-cycle write strobe for oData/oAddr.
- oGroupStart  out  1  one-cycle pulse coincident with the oWrEn for oAddr=0.
- oLocked  out  1  high while in LOCKED.
- oErrCnt  out  16  saturating count of missed markers while locked.

## Operation

- Reset values: oData=0, oAddr=0, oWrEn=0, oGroupStart=0, oLocked=0, oErrCnt=0. Internal state: HUNT, shift register=0, fill count=0, bit/word/confirm/miss counters=0.
- Every strobe shifts iSerial into a 12-bit register at the LSB. With iBitEn low, no state changes and no strobes are issued.
- HUNT:
  - The 12-bit shift-register value is compared with SYNC_WORD after each strobe.
  - A compare counts only once 12 or more bits have been shifted since entry to HUNT.
  - On a match: go to CHECK with bit count=0, word count=1, confirm=0.
- CHECK:
  - Bit count runs 0..11. At 11 it wraps, and word count increments modulo GROUP_WORDS.
  - When a word completes with word count 0, the assembled word is compared with SYNC_WORD.
  - Match: confirm+1. When confirm reaches LOCK_GROUPS, go to LOCKED.
  - Mismatch: return to HUNT with fill count=0.
  - No writes are issued in CHECK.
- LOCKED:
  - Every completed word is written with oData=word and oAddr=word index. The sync word is written at address 0.
  - On the word-0 compare:
    - Match: miss=0.
    - Mismatch: miss+1, and oErrCnt+1, saturating at 16'hFFFF.
    - Miss reaching MISS_LIMIT: go to HUNT and clear oLocked. That word is still written.
  - While misses stay below MISS_LIMIT, the decoder keeps writing on the expected word grid.
- oErrCnt clears only on reset. It holds its value across loss and regain of lock.

## Timing

- All outputs are registered. A strobe completing a word at cycle n gives oWrEn/oData/oAddr at n+1, high for exactly one cycle.
- Entering LOCKED:
  - oLocked rises at n+1, where n is the strobe completing the LOCK_GROUPS-th confirming marker.
  - The same cycle carries the first write: addr 0 with oGroupStart.
- Losing lock: oLocked falls at n+1, alongside the final write of that marker word.
- oErrCnt updates at n+1 of the missed marker's last strobe.
- Minimum write spacing is 12 cycles, with iBitEn held high.
- Reset asserted mid-word or mid-group aborts immediately. Outputs take reset values asynchronously, and no partial write is issued.

## Test plan

- Stream of groups with GROUP_WORDS=1024 and SYNC_WORD at index 0, iBitEn held high:
  - oLocked rises after the third marker (first marker plus LOCK_GROUPS=2).
  - The first write is addr 0, data 12'hE38, with oGroupStart.
  - 1024 writes follow per group, each one cycle after its word's 12th bit.
- SYNC_WORD pattern placed mid-group before a true marker, with wrong spacing: CHECK rejects it and returns to HUNT; lock is gained on the real grid; no writes occur before lock.
- Locked, then markers corrupted in 2 consecutive groups:
  - oErrCnt = 2 and oLocked stays high.
  - Writes continue at the same addresses.
  - A good marker clears the miss count.
  - Three consecutive bad markers drop oLocked, and oErrCnt = 5.
- iBitEn pulsed one cycle in four: same words and addresses as with iBitEn continuous; oWrEn still lasts one cycle.
- Reset low mid-word while locked: all outputs 0 at once. After release, relock takes the full LOCK_GROUPS sequence and oErrCnt restarts at 0.
- oErrCnt forced near saturation by a long corrupted-marker run, with MISS_LIMIT raised: it holds at 16'hFFFF and does not wrap.
